// File: rtl/mem_access_pkg.sv
// Shared types for the load/store engine: FSM states, op decode and default widths.
package mem_access_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // {ldr, str} taken directly as the op code
    typedef enum logic [1:0] {
        OP_ALU = 2'b00,
        OP_STR = 2'b01,
        OP_LDR = 2'b10,
        OP_BAD = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic ldr, input logic str);
        return op_e'({ldr, str});
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clear/enable cycle counter; limit is high during the TIMEOUT-th enabled cycle so the
// RAM request stays up for exactly TIMEOUT cycles before an abort.
module mem_timeout_ctr
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic limit
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign limit = en && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (en && !limit)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine between execute and data RAM with write-back select and timeout abort.
// Optional byte lanes (byte_op / ram_be) are enabled with MEM_BYTE_ACCESS_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ldr,
    input  logic              str,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
`ifdef MEM_BYTE_ACCESS_EN
    input  logic              byte_op,
    output logic [DATA_W/8-1:0] ram_be,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wb_sel,
    output logic [DATA_W-1:0] load_data,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    state_e state_q, state_d;
    op_e    op;
    logic   limit;
    logic   is_mem;

    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              err_q, err_d;
    logic              wb_sel_q, wb_sel_d;
    logic [DATA_W-1:0] rdata_sel;

    assign op     = decode_op(ldr, str);
    assign is_mem = (op == OP_LDR) || (op == OP_STR);

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == IDLE),
        .en    (state_q == ACCESS),
        .limit (limit)
    );

`ifdef MEM_BYTE_ACCESS_EN
    logic [BE_W-1:0][7:0] rdata_bytes;
    logic                 byte_q, byte_d;
    logic [BE_W-1:0]      be_q, be_d;

    assign rdata_bytes = ram_rdata;
    assign rdata_sel   = byte_q ? {{(DATA_W-8){1'b0}}, rdata_bytes[ram_addr_q[OFF_W-1:0]]}
                                : ram_rdata;
    assign ram_be      = be_q;
`else
    assign rdata_sel   = ram_rdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = is_mem ? ACCESS : DONE;
            ACCESS:  if (ram_ack || limit) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ACCESS);
        ram_req = (state_q == ACCESS);
        done    = (state_q == DONE);
    end

    // err/wb_sel are set only on the edge into DONE, so they live exactly one cycle
    always_comb begin
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        load_data_d = load_data_q;
        err_d       = 1'b0;
        wb_sel_d    = 1'b0;
`ifdef MEM_BYTE_ACCESS_EN
        byte_d      = byte_q;
        be_d        = be_q;
`endif
        if (state_q == IDLE && start) begin
            err_d = (op == OP_BAD);
            if (is_mem) begin
                ram_we_d = (op == OP_STR);
`ifdef MEM_BYTE_ACCESS_EN
                byte_d      = byte_op;
                ram_addr_d  = addr;
                be_d        = byte_op ? ({{(BE_W-1){1'b0}}, 1'b1} << addr[OFF_W-1:0]) : '1;
                ram_wdata_d = byte_op ? {BE_W{store_data[7:0]}} : store_data;
`else
                ram_addr_d  = addr & ~ADDR_W'(BE_W - 1);
                ram_wdata_d = store_data;
`endif
            end
        end
        if (state_q == ACCESS) begin
            if (ram_ack) begin
                wb_sel_d = !ram_we_q;
                if (!ram_we_q) load_data_d = rdata_sel;
            end else if (limit) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            load_data_q <= '0;
            err_q       <= 1'b0;
            wb_sel_q    <= 1'b0;
`ifdef MEM_BYTE_ACCESS_EN
            byte_q      <= 1'b0;
            be_q        <= '0;
`endif
        end else begin
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
            wb_sel_q    <= wb_sel_d;
`ifdef MEM_BYTE_ACCESS_EN
            byte_q      <= byte_d;
            be_q        <= be_d;
`endif
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign load_data = load_data_q;
    assign err       = err_q;
    assign wb_sel    = wb_sel_q;

endmodule
